// File: rtl/wb_project_mux_ctrl_if.sv
// Wishbone slave bundle between the management SoC (master) and the project
// mux controller (slave). Signal names follow the Caravel wbs_* naming.
interface wb_project_mux_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_project_mux_ctrl.sv
// Project-array select controller: WB register file plus the handover
// sequencer (drain, switch, timed reset, run) and a clock-enable divider.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | EN=0 or not yet started; project disabled and held in reset
//   S_DRAIN  | one cycle with the outgoing project disabled
//   S_SWITCH | one cycle; select bus takes SEL, reset timer loaded
//   S_RESET  | new project enabled but held in reset until the timer ends
//   S_RUN    | project enabled and released; clock-enable divider running
module wb_project_mux_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SEL_W     = 8,
  parameter logic [7:0]  RST_DEF   = 8'd10
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_project_mux_ctrl_if.slave   wbs,
  output logic [SEL_W-1:0]       proj_sel,
  output logic                   proj_ena,
  output logic                   proj_rst_n,
  output logic                   proj_clk_en,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SWITCH,
    S_RESET,
    S_RUN
  } state_e;

  state_e           state_q;
  logic             ack_q;
  logic [31:0]      dat_q;
  logic             en_q;
  logic             srst_q;
  logic [7:0]       sel_q;
  logic [7:0]       rst_cycles_q;
  logic [7:0]       clkdiv_q;
  logic [SEL_W-1:0] proj_sel_q;
  logic             ena_q;
  logic             rst_n_q;
  logic             busy_q;
  logic             clk_en_q;
  logic [7:0]       rst_cnt_q;
  logic [7:0]       div_q;
  logic [7:0]       div_lim_q;

  logic             hit;
  logic             acc;
  logic             wr;
  logic [1:0]       off;
  logic [31:0]      rd_d;
  logic             div_wrap;
  logic [7:0]       div_d;
  logic [7:0]       div_lim_d;
  logic             unused_bits;

  always_comb begin
    hit  = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // the ack cycle itself never starts a new access, so a held strobe alternates
    acc  = hit & ~ack_q;
    wr   = acc & wbs.wbs_we_i;
    off  = wbs.wbs_adr_i[3:2];
    rd_d = '0;
    case (off)
      2'd0: rd_d = {16'h0, sel_q, 7'h0, en_q};
      2'd1: rd_d = {16'h0, 8'(proj_sel_q), 5'h0, rst_n_q, ena_q, busy_q};
      2'd2: rd_d = {24'h0, rst_cycles_q};
      2'd3: rd_d = {24'h0, clkdiv_q};
      default: rd_d = '0;
    endcase
    div_wrap    = (div_q == div_lim_q);
    div_d       = div_wrap ? 8'd0 : div_q + 8'd1;
    div_lim_d   = div_wrap ? clkdiv_q : div_lim_q;
    unused_bits = ^{wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2], wbs.wbs_adr_i[1:0]};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      en_q         <= 1'b0;
      srst_q       <= 1'b0;
      sel_q        <= '0;
      rst_cycles_q <= RST_DEF;
      clkdiv_q     <= '0;
    end else begin
      ack_q  <= acc;
      dat_q  <= (acc & ~wbs.wbs_we_i) ? rd_d : '0;
      srst_q <= wr & (off == 2'd0) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1] & ~busy_q;
      if (wr) begin
        case (off)
          2'd0: begin
            if (wbs.wbs_sel_i[0]) en_q  <= wbs.wbs_dat_i[0];
            if (wbs.wbs_sel_i[1]) sel_q <= wbs.wbs_dat_i[15:8];
          end
          2'd2: if (wbs.wbs_sel_i[0]) rst_cycles_q <= wbs.wbs_dat_i[7:0];
          2'd3: if (wbs.wbs_sel_i[0]) clkdiv_q     <= wbs.wbs_dat_i[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      proj_sel_q <= '0;
      ena_q      <= 1'b0;
      rst_n_q    <= 1'b0;
      busy_q     <= 1'b0;
      clk_en_q   <= 1'b0;
      rst_cnt_q  <= '0;
      div_q      <= '0;
      div_lim_q  <= '0;
    end else if (!en_q) begin
      state_q  <= S_IDLE;
      ena_q    <= 1'b0;
      rst_n_q  <= 1'b0;
      busy_q   <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_DRAIN;
          busy_q  <= 1'b1;
        end
        S_DRAIN: begin
          state_q    <= S_SWITCH;
          proj_sel_q <= SEL_W'(sel_q);
          rst_cnt_q  <= (rst_cycles_q == 8'd0) ? 8'd1 : rst_cycles_q;
        end
        S_SWITCH: begin
          state_q <= S_RESET;
          ena_q   <= 1'b1;
        end
        S_RESET: begin
          if (rst_cnt_q == 8'd1) begin
            state_q   <= S_RUN;
            rst_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            div_q     <= 8'd0;
            div_lim_q <= clkdiv_q;
            clk_en_q  <= (clkdiv_q == 8'd0);
          end else begin
            rst_cnt_q <= rst_cnt_q - 8'd1;
          end
        end
        S_RUN: begin
          if ((SEL_W'(sel_q) != proj_sel_q) || srst_q) begin
            state_q  <= S_DRAIN;
            ena_q    <= 1'b0;
            rst_n_q  <= 1'b0;
            busy_q   <= 1'b1;
            clk_en_q <= 1'b0;
          end else begin
            div_q     <= div_d;
            div_lim_q <= div_lim_d;
            clk_en_q  <= (div_d == div_lim_d);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ena_q    <= 1'b0;
          rst_n_q  <= 1'b0;
          busy_q   <= 1'b0;
          clk_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign proj_sel      = proj_sel_q;
  assign proj_ena      = ena_q;
  assign proj_rst_n    = rst_n_q;
  assign proj_clk_en   = clk_en_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_wb_project_mux_ctrl.sv
// Randomised bench for wb_project_mux_ctrl: expected handover waveforms are
// computed arithmetically from the sequence timing, registers from a shadow map.
module tb_wb_project_mux_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic       clk;
  logic       rst;
  logic [7:0] proj_sel;
  logic       proj_ena;
  logic       proj_rst_n;
  logic       proj_clk_en;
  logic       busy;

  wb_project_mux_ctrl_if wbs();

  wb_project_mux_ctrl #(
    .BASE_ADDR (BASE),
    .SEL_W     (8),
    .RST_DEF   (8'd10)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (wbs),
    .proj_sel    (proj_sel),
    .proj_ena    (proj_ena),
    .proj_rst_n  (proj_rst_n),
    .proj_clk_en (proj_clk_en),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // shadow register map
  logic [7:0] m_sel;
  logic       m_en;
  logic [7:0] m_rst;
  logic [7:0] m_div;
  logic [7:0] m_cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {20'h0, busy, proj_ena, proj_rst_n, proj_clk_en, proj_sel};
  endfunction

  // Expected outputs c cycles after the ack of the triggering write.
  function automatic logic [31:0] exp_vec(int c, int neff, int d, logic [7:0] o, logic [7:0] s);
    logic b, e, r, k;
    logic [7:0] ps;
    ps = (c >= 2) ? s : o;
    k  = 1'b0;
    if (c <= 2) begin
      b = 1'b1; e = 1'b0; r = 1'b0;
    end else if (c <= 2 + neff) begin
      b = 1'b1; e = 1'b1; r = 1'b0;
    end else begin
      b = 1'b0; e = 1'b1; r = 1'b1;
      k = (((c - 2 - neff) % (d + 1)) == 0);
    end
    return {20'h0, b, e, r, k, ps};
  endfunction

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, output logic [31:0] rdat,
                      output logic acked, output int lat);
    @(negedge clk);
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_adr_i = adr;
    wbs.wbs_sel_i = sel;
    wbs.wbs_dat_i = wdat;
    acked = 1'b0;
    lat   = 0;
    rdat  = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (wbs.wbs_ack_o) begin
        acked = 1'b1;
        lat   = i;
        rdat  = wbs.wbs_dat_o;
        break;
      end
    end
    @(negedge clk);
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input int offs, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd;
    logic a;
    int l;
    xfer(1'b1, BASE + 32'(offs * 4), sel, d, rd, a, l);
    chk($sformatf("wr%0d_ack", offs), {31'h0, a}, 32'h1);
    if (offs == 0) begin
      if (sel[0]) m_en  = d[0];
      if (sel[1]) m_sel = d[15:8];
    end else if (offs == 2 && sel[0]) m_rst = d[7:0];
    else if (offs == 3 && sel[0]) m_div = d[7:0];
  endtask

  task automatic rd_chk(input string tag, input int offs, input logic [31:0] exp);
    logic [31:0] rd;
    logic a;
    int l;
    xfer(1'b0, BASE + 32'(offs * 4), 4'hF, 32'h0, rd, a, l);
    chk({tag, "_lat"}, 32'(l), 32'd1);
    chk(tag, rd, exp);
  endtask

  task automatic run_seq(input string tag, input int n, input int d, input logic [7:0] o, input logic [7:0] s);
    int neff;
    int len;
    neff = (n == 0) ? 1 : n;
    len  = 3 + neff + 2 * (d + 1);
    for (int c = 1; c <= len; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_c%0d", tag, c), obs_vec(), exp_vec(c, neff, d, o, s));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_sel = '0; m_en = 1'b0; m_rst = 8'd10; m_div = '0; m_cur = '0;
  endtask

  initial begin
    logic [31:0] rdat;
    logic        a;
    int          l;
    int          n, d;
    logic [7:0]  s;
    logic [31:0] cw;

    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_dat_i = '0;
    wbs.wbs_adr_i = '0;
    do_reset();

    #1;
    chk("rst_outs", obs_vec(), 32'h0);
    chk("rst_ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
    rd_chk("rst_status", 1, 32'h0);
    rd_chk("rst_rstcyc", 2, 32'h0000_000A);
    rd_chk("rst_clkdiv", 3, 32'h0);

    // first handover: default 10 reset cycles, CLKDIV 0 holds the strobe high
    wr(0, 32'h0000_0501, 4'hF);
    run_seq("sel5", 10, 0, m_cur, 8'h05);
    m_cur = 8'h05;

    wr(3, 32'h3, 4'hF);
    wr(0, 32'h0000_0901, 4'hF);
    run_seq("sel9", 10, 3, m_cur, 8'h09);
    m_cur = 8'h09;

    wr(0, 32'h0000_0903, 4'hF);
    run_seq("srst9", 10, 3, m_cur, 8'h09);

    wr(2, 32'h0, 4'hF);
    wr(3, 32'h0, 4'hF);
    wr(0, 32'h0000_0A01, 4'hF);
    run_seq("rst0", 0, 0, m_cur, 8'h0A);
    m_cur = 8'h0A;

    for (int it = 0; it < 16; it++) begin
      n = int'($urandom_range(0, 12));
      d = int'($urandom_range(0, 5));
      s = 8'($urandom_range(0, 255));
      wr(2, 32'(n), 4'hF);
      wr(3, 32'(d), 4'hF);
      cw = {16'h0, s, 8'h01};
      if (s == m_cur) cw[1] = 1'b1;
      wr(0, cw, 4'hF);
      run_seq($sformatf("rnd%0d", it), n, d, m_cur, s);
      m_cur = s;
    end

    rd_chk("ctrl_rb", 0, {16'h0, m_sel, 7'h0, m_en});
    rd_chk("rstcyc_rb", 2, {24'h0, m_rst});
    rd_chk("clkdiv_rb", 3, {24'h0, m_div});
    rd_chk("status_run", 1, {16'h0, m_cur, 8'h06});
    wr(1, 32'hFFFF_FFFF, 4'hF);
    rd_chk("status_ro", 1, {16'h0, m_cur, 8'h06});

    // byte-lane write touches only SEL
    wr(2, 32'd4, 4'hF);
    wr(3, 32'd1, 4'hF);
    wr(0, 32'h0000_0301, 4'hF);
    run_seq("sel3", 4, 1, m_cur, 8'h03);
    m_cur = 8'h03;
    wr(0, 32'h0000_0700, 4'b0010);
    run_seq("bytesel", 4, 1, m_cur, 8'h07);
    m_cur = 8'h07;
    rd_chk("ctrl_byte", 0, 32'h0000_0701);

    xfer(1'b0, BASE + 32'h20, 4'hF, 32'h0, rdat, a, l);
    chk("miss_ack", {31'h0, a}, 32'h0);

    // held strobe: ack on alternate cycles, data only in the ack cycle
    @(negedge clk);
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_adr_i = BASE + 32'h8;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_ack%0d", i), {31'h0, wbs.wbs_ack_o}, {31'h0, 1'(i % 2)});
      chk($sformatf("hold_dat%0d", i), wbs.wbs_dat_o, (i % 2 == 1) ? {24'h0, m_rst} : 32'h0);
    end
    @(negedge clk);
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;

    // EN cleared during RESET
    wr(2, 32'd10, 4'hF);
    wr(0, 32'h0000_1101, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    chk("en0_pre", obs_vec(), exp_vec(5, 10, 0, m_cur, 8'h11));
    wr(0, 32'h0000_1100, 4'hF);
    @(posedge clk);
    #1;
    chk("en0_c1", obs_vec(), {20'h0, 4'b0000, 8'h11});
    @(posedge clk);
    #1;
    chk("en0_c2", obs_vec(), {20'h0, 4'b0000, 8'h11});
    m_cur = 8'h11;

    // asynchronous reset in the middle of RESET with an access in flight
    wr(0, 32'h0000_2201, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    chk("arst_pre", obs_vec(), exp_vec(5, 10, 0, m_cur, 8'h22));
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_adr_i = BASE + 32'h4;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_outs", obs_vec(), 32'h0);
    chk("arst_ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_ack2", {31'h0, wbs.wbs_ack_o}, 32'h0);
    chk("arst_dat", wbs.wbs_dat_o, 32'h0);
    @(negedge clk);
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    rst = 1'b0;
    m_sel = '0; m_en = 1'b0; m_rst = 8'd10; m_div = '0; m_cur = '0;
    rd_chk("post_rst_ctrl", 0, 32'h0);
    rd_chk("post_rst_rstcyc", 2, 32'h0000_000A);
    @(posedge clk);
    #1;
    chk("post_rst_outs", obs_vec(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_project_mux_ctrl.md
Name: wb_project_mux_ctrl

Overview:
Wishbone-slave controller that selects which user project in the shared project array is active and sequences its handover. On every project change it disables the outgoing project, switches the select bus, holds the new project in reset for a programmable time, then releases it. It also provides a programmable clock-enable strobe for the active project. It sits inside user_project_wrapper on the WB MI A slave port, between the management SoC and the project mux.

Parameters:
BASE_ADDR, 32'h3000_0000, register window base; decode on wbs_adr_i[31:4].
SEL_W, 8, width of the project select bus.
RST_DEF, 8'd10, reset value of the RST_CYCLES register.

Ports:
wb_clk_i  input  1  sole clock
wb_rst_i  input  1  asynchronous, active-high reset
wbs_stb_i  input  1  WB strobe
wbs_cyc_i  input  1  WB cycle
wbs_we_i  input  1  WB write enable
wbs_sel_i  input  4  WB byte enables
wbs_dat_i  input  32  WB write data
wbs_adr_i  input  32  WB byte address
wbs_ack_o  output  1  WB acknowledge
wbs_dat_o  output  32  WB read data
proj_sel  output  SEL_W  active project index
proj_ena  output  1  project enable
proj_rst_n  output  1  project reset, active low
proj_clk_en  output  1  one-cycle clock-enable strobe for the project
busy  output  1  handover sequence in progress

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, proj_sel=0, proj_ena=0, proj_rst_n=0, proj_clk_en=0, busy=0, all registers 0 except RST_CYCLES=RST_DEF.
- Register map (offset = adr[3:2]):
  - 0 CTRL: [0] EN, [1] SRST (write-1 pulse, reads 0), [15:8] SEL.
  - 1 STATUS (RO): [0] busy, [1] proj_ena, [2] proj_rst_n, [15:8] proj_sel.
  - 2 RST_CYCLES: [7:0].
  - 3 CLKDIV: [7:0].
  - Unused bits read 0.
- WB protocol:
  - An access hits when stb & cyc and adr[31:4]==BASE_ADDR[31:4].
  - wbs_ack_o is asserted for one cycle, one cycle after the hit. No ack on a miss.
  - ack is never asserted in two consecutive cycles; a held strobe is acked every other cycle.
  - Writes honour wbs_sel_i per byte and commit in the ack cycle.
  - wbs_dat_o is valid in the ack cycle and 0 otherwise.
  - Writes to STATUS are ignored but still acked.
- FSM states: IDLE, DRAIN, SWITCH, RESET, RUN.
  - IDLE: proj_ena=0, proj_rst_n=0. Goes to DRAIN when EN=1.
  - DRAIN (1 cycle): proj_ena=0, proj_rst_n=0. Goes to SWITCH.
  - SWITCH (1 cycle): proj_sel<=SEL, reset counter loads max(RST_CYCLES,1). Goes to RESET.
  - RESET: proj_ena=1, proj_rst_n=0, counter decrements each cycle. Goes to RUN in the cycle after the counter reaches 1, so proj_rst_n is low for exactly max(RST_CYCLES,1) cycles in RESET.
  - RUN: proj_ena=1, proj_rst_n=1. Goes to DRAIN if SEL!=proj_sel or SRST is written with 1.
  - busy=1 in DRAIN, SWITCH and RESET.
- EN=0 in any state forces IDLE on the next cycle. This has priority over all other transitions; proj_sel holds its value.
- CTRL writes during busy update the registers only. In that case SEL is sampled at SWITCH. A SEL change that commits after SWITCH is acted on from RUN (it triggers a new sequence there).
- SRST written while busy is ignored.
- Clock enable:
  - An 8-bit divider counter runs only in RUN.
  - proj_clk_en pulses high for 1 cycle every CLKDIV+1 cycles.
  - CLKDIV=0 gives proj_clk_en held high.
  - The counter clears on RUN entry, so the first pulse occurs in the (CLKDIV+1)th RUN cycle.
  - A CLKDIV write takes effect at the next counter wrap.
- Asynchronous reset asserted mid-sequence returns every output and register to its reset value immediately, with no ack for any in-flight access.

Test Plan:
- Reset then read STATUS -> ack 1 cycle after stb; data 0x0000_0000. Read RST_CYCLES -> 0x0000_000A.
- Write CTRL=0x0000_0501 -> busy=1 for 1+1+10 cycles; proj_sel=5 from SWITCH; proj_rst_n low for exactly 10 cycles; then proj_ena=1, proj_rst_n=1, busy=0.
- In RUN with CLKDIV=3 -> proj_clk_en pulses every 4th cycle; with CLKDIV=0 -> held high; with RST_CYCLES=0 -> reset held exactly 1 cycle.
- In RUN, write CTRL=0x0000_0901 -> proj_ena drops for 2 cycles, proj_sel becomes 9, reset sequence repeats. Write CTRL=0x0000_0903 -> same sequence with proj_sel unchanged.
- Write CTRL EN=0 during RESET -> next cycle proj_ena=0, proj_rst_n=0, busy=0, state IDLE.
- Access at BASE_ADDR+0x20 -> no ack. Byte write wbs_sel_i=4'b0010, data 0x0000_0700 -> only SEL changes. Assert wb_rst_i mid-RESET -> all outputs 0 asynchronously.
